// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the signed 4-bit division sequencer.
//   state_e  : controller states
//   WIDTH    : operand width (the complement unit is 4-bit)
//   NEG_MIN  : most-negative operand, which the abs unit cannot represent
package div_pkg;

  localparam int unsigned WIDTH = 4;
  localparam logic [WIDTH-1:0] NEG_MIN = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_LOAD,
    S_DIV,
    S_SIGN
  } state_e;

endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division iteration on magnitudes.
//   r_i, q_i  : partial remainder and shifting quotient/dividend register
//   mag_b_i   : divisor magnitude (non-zero)
//   r_o, q_o  : updated partial remainder and quotient register
module div_restore_step #(
  parameter int unsigned WIDTH = div_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] mag_b_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // t never exceeds 2*mag_b-1, so the subtraction result always fits WIDTH bits.
  always_comb begin
    t    = {r_i, q_i[WIDTH-1]};
    ge   = (t >= {1'b0, mag_b_i});
    diff = t[WIDTH-1:0] - mag_b_i;
    r_o  = ge ? diff : t[WIDTH-1:0];
    q_o  = {q_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/division_4bits_ctrl.sv
// division_4bits_ctrl: sequencer for signed 4-bit two's-complement division.
// Uses the shared complement unit twice to obtain operand magnitudes, runs a
// 4-iteration restoring divide, then sign-corrects (quotient truncates toward
// zero, remainder follows the dividend's sign).
//   clk, rst              : rising-edge clock, asynchronous active-low reset
//   start, dividend, divisor : request and operands, sampled only in IDLE
//   busy, done            : busy from acceptance until done; done is a 1-cycle pulse
//   quotient, remainder   : results, held until overwritten by the next result
//   div_by_zero, range_err: error flags valid with done
//   comp_sel, comp_a, comp_b, comp_ci, comp_sum : complement (abs) unit interface
module division_4bits_ctrl #(
  parameter int unsigned WIDTH = div_pkg::WIDTH,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             range_err,
  output logic             comp_sel,
  output logic [WIDTH-1:0] comp_a,
  output logic [WIDTH-1:0] comp_b,
  output logic             comp_ci,
  input  logic [WIDTH-1:0] comp_sum
);

  import div_pkg::*;

  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             rerr_q, rerr_d;

  logic [WIDTH-1:0] step_r, step_q;
  logic             sa, sb;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .r_i     (wr_q),
    .q_i     (wq_q),
    .mag_b_i (mag_b_q),
    .r_o     (step_r),
    .q_o     (step_q)
  );

  assign sa = dvd_q[WIDTH-1];
  assign sb = dvs_q[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    wq_d     = wq_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    rerr_d   = rerr_q;
    comp_sel = 1'b0;
    comp_a   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          dbz_d  = 1'b0;
          rerr_d = 1'b0;
          busy_d = 1'b1;
          if (dividend == NEG_MIN || divisor == NEG_MIN) begin
            // Zero working values make the SIGN state emit q=r=0 regardless of signs.
            rerr_d  = 1'b1;
            wq_d    = '0;
            wr_d    = '0;
            state_d = S_SIGN;
          end else begin
            state_d = S_ABS_A;
          end
        end
      end
      S_ABS_A: begin
        comp_sel = 1'b1;
        comp_a   = dvd_q;
        state_d  = S_ABS_B;
      end
      S_ABS_B: begin
        comp_sel = 1'b1;
        comp_a   = dvs_q;
        mag_a_d  = comp_sum;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        if (comp_sum == '0) begin
          dbz_d   = 1'b1;
          quo_d   = '0;
          rem_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          mag_b_d = comp_sum;
          wq_d    = mag_a_q;
          wr_d    = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        wq_d  = step_q;
        wr_d  = step_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        quo_d   = (sa ^ sb) ? (~wq_q + 1'b1) : wq_q;
        rem_d   = sa ? (~wr_q + 1'b1) : wr_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      wq_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      wq_q    <= wq_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      rerr_q  <= rerr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign range_err   = rerr_q;
  assign comp_b      = '0;
  assign comp_ci     = 1'b1;

endmodule

// File: tb/tb_division_4bits_ctrl.sv
// tb_division_4bits_ctrl: self-checking bench for division_4bits_ctrl with a
// registered abs-unit model, directed cases and randomized operands.
module tb_division_4bits_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero, range_err, comp_sel, comp_ci;
  logic [3:0] quotient, remainder, comp_a, comp_b;
  logic [3:0] comp_sum = '0;

  int checks = 0;
  int errors = 0;
  logic [3:0] last_q = '0;
  logic [3:0] last_r = '0;

  always #5 clk = ~clk;

  division_4bits_ctrl #(.WIDTH(4), .ITER(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .range_err   (range_err),
    .comp_sel    (comp_sel),
    .comp_a      (comp_a),
    .comp_b      (comp_b),
    .comp_ci     (comp_ci),
    .comp_sum    (comp_sum)
  );

  // Complement unit: registered absolute value of comp_a when selected.
  always @(posedge clk) begin
    if (comp_sel) comp_sum <= comp_a[3] ? 4'(-comp_a) : comp_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer division (truncating) on the operand values.
  function automatic void ref_div(input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] q, output logic [3:0] r,
                                  output logic dz, output logic re, output int lat);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    q = '0; r = '0; dz = 1'b0; re = 1'b0;
    if (sa == -8 || sb == -8) begin
      re = 1'b1; lat = 1;
    end else if (sb == 0) begin
      dz = 1'b1; lat = 3;
    end else begin
      q = 4'(sa / sb); r = 4'(sa % sb); lat = 8;
    end
  endfunction

  // Called #1 after a clock edge (or with the clock low); start is sampled at the next edge k.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit poke);
    logic [3:0] eq, er;
    logic edz, ere;
    int elat;
    int lat = 0;
    int abs_cnt = 0;
    int busy_low = 0;
    ref_div(a, b, eq, er, edz, ere, elat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    check("busy_at_k", 32'(busy), 32'd1);
    check("done_low_at_k", 32'(done), 32'd0);
    for (int c = 1; c <= 20; c++) begin
      if (comp_sel) abs_cnt++;
      if (poke && c == 2) begin
        start = 1'b1; dividend = 4'd6; divisor = 4'd1;
      end
      if (poke && c == 3) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) busy_low++;
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'(elat));
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edz));
    check("range_err", 32'(range_err), 32'(ere));
    check("busy_at_done", 32'(busy), 32'd0);
    check("busy_gaps", 32'(busy_low), 32'd0);
    check("abs_uses", 32'(abs_cnt), ere ? 32'd0 : 32'd2);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    #1;
    check("reset_outputs",
          32'({busy, done, quotient, remainder, div_by_zero, range_err, comp_sel, comp_a}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases; the first also pulses start while busy with other operands.
    run_op(4'd7,    4'd2,    1'b1);
    run_op(4'b1001, 4'd2,    1'b0);
    run_op(4'd6,    4'b1101, 1'b0);
    run_op(4'b1010, 4'b1101, 1'b0);
    run_op(4'd5,    4'd0,    1'b0);
    run_op(4'b1000, 4'd3,    1'b0);
    run_op(4'd3,    4'b1000, 1'b0);

    // Reset in the middle of a divide.
    dividend = 4'd7; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_reset_outputs",
          32'({busy, done, quotient, remainder, div_by_zero, range_err, comp_sel, comp_a}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 32'({busy, done}), 32'd0);
    run_op(4'd7, 4'b1110, 1'b0);

    // Randomized operands, mixing back-to-back starts and idle gaps.
    for (int n = 0; n < 60; n++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          @(posedge clk); #1;
          check("done_pulse", 32'(done), 32'd0);
          check("result_hold", 32'({quotient, remainder}), 32'({last_q, last_r}));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
